// File: rtl/fsm_lock_param_if.sv
// Button/status bundle of the parametrised combination lock.
// master drives buttons and observes status; slave is the lock itself.
interface fsm_lock_param_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_in;
    logic               prog_in;
    logic               out;
    logic               lockout_out;
    logic [3:0]         fail_cnt_out;
    logic [6:0]         hex_display;

    modport master (
        output btn_in, prog_in,
        input  out, lockout_out, fail_cnt_out, hex_display
    );

    modport slave (
        input  btn_in, prog_in,
        output out, lockout_out, fail_cnt_out, hex_display
    );
endinterface

// File: rtl/fsm_lock_param.sv
// Parametrised combination lock: N-button code entry, timed unlock, lockout after repeated failures.
// Define FSM_LOCK_PROG_EN to allow reprogramming the code from the OPEN state.
module fsm_lock_param #(
    parameter int NUM_BTN     = 2,
    parameter int CODE_LEN    = 4,
    parameter logic [CODE_LEN*((NUM_BTN > 1) ? $clog2(NUM_BTN) : 1)-1:0] CODE = 4'b0110,
    parameter int MAX_FAIL    = 3,
    parameter int UNLOCK_CYC  = 16,
    parameter int LOCKOUT_CYC = 32
) (
    input  logic            clk,
    input  logic            reset_in,
    fsm_lock_param_if.slave bus
);
    localparam int IDX_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int CODE_W  = CODE_LEN * IDX_W;
    localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [3:0]       LAST_DIG    = 4'(CODE_LEN - 1);
    localparam logic [3:0]       FAIL_LAST   = 4'(MAX_FAIL - 1);
    localparam logic [3:0]       FAIL_MAX    = 4'(MAX_FAIL);
    localparam logic [TMR_W-1:0] UNLOCK_LAST = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYC - 1);

    localparam logic [6:0] SEG_U = 7'b0111110;
    localparam logic [6:0] SEG_L = 7'b0111000;
    localparam logic [6:0] SEG_P = 7'b1110011;
    localparam logic [6:0] SEG_0 = 7'b0111111;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
`ifdef FSM_LOCK_PROG_EN
        , ST_PROG  = 2'd3
`endif
    } state_t;

    state_t             state, nxt_state;
    logic [NUM_BTN-1:0] btn_q;
    logic [3:0]         dig_cnt, nxt_cnt;
    logic               mismatch, nxt_mis;
    logic [3:0]         fail_cnt, nxt_fail;
    logic [TMR_W-1:0]   timer, nxt_timer;
    logic [CODE_W-1:0]  code_reg;

    logic [NUM_BTN-1:0] rise;
    logic               press, multi, digit_bad;
    logic [IDX_W-1:0]   press_idx, cur_digit;

    // Edge detector runs in every state so a held button never re-fires after a state change.
    assign rise      = bus.btn_in & ~btn_q;
    assign press     = |rise;
    assign multi     = |(rise & (rise - NUM_BTN'(1)));
    assign cur_digit = code_reg[int'(dig_cnt)*IDX_W +: IDX_W];
    assign digit_bad = multi || (press_idx != cur_digit);

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rise[i]) press_idx = IDX_W'(i);
        end
    end

`ifdef FSM_LOCK_PROG_EN
    logic [CODE_W-1:0] prog_buf, nxt_prog, nxt_code;
`else
    logic unused_prog;
    assign unused_prog = bus.prog_in;
    assign code_reg    = CODE;
`endif

    function automatic logic [6:0] seg_of(input state_t s, input logic [3:0] n);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (s)
            ST_OPEN:    seg = SEG_U;
            ST_LOCKOUT: seg = SEG_L;
`ifdef FSM_LOCK_PROG_EN
            ST_PROG:    seg = SEG_P;
`endif
            default: begin
                case (n)
                    4'd0: seg = SEG_0;
                    4'd1: seg = 7'b0000110;
                    4'd2: seg = 7'b1011011;
                    4'd3: seg = 7'b1001111;
                    4'd4: seg = 7'b1100110;
                    4'd5: seg = 7'b1101101;
                    4'd6: seg = 7'b1111101;
                    4'd7: seg = 7'b0000111;
                    4'd8: seg = 7'b1111111;
                    4'd9: seg = 7'b1101111;
                    default: seg = 7'b0000000;
                endcase
            end
        endcase
        return seg;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = dig_cnt;
        nxt_mis   = mismatch;
        nxt_fail  = fail_cnt;
        nxt_timer = timer;
`ifdef FSM_LOCK_PROG_EN
        nxt_prog  = prog_buf;
        nxt_code  = code_reg;
`endif
        case (state)
            ST_ENTRY: begin
                if (press) begin
                    if (dig_cnt == LAST_DIG) begin
                        // Full code always consumed before judging, so timing never reveals the length.
                        nxt_cnt = 4'd0;
                        nxt_mis = 1'b0;
                        if (!(mismatch || digit_bad)) begin
                            nxt_state = ST_OPEN;
                            nxt_fail  = 4'd0;
                            nxt_timer = '0;
                        end else if (fail_cnt >= FAIL_LAST) begin
                            nxt_state = ST_LOCKOUT;
                            nxt_fail  = FAIL_MAX;
                            nxt_timer = '0;
                        end else begin
                            nxt_fail  = fail_cnt + 4'd1;
                        end
                    end else begin
                        nxt_cnt = dig_cnt + 4'd1;
                        nxt_mis = mismatch || digit_bad;
                    end
                end
            end
            ST_OPEN: begin
`ifdef FSM_LOCK_PROG_EN
                if (press && bus.prog_in) begin
                    nxt_state = ST_PROG;
                    nxt_cnt   = 4'd0;
                end else
`endif
                if (timer == UNLOCK_LAST) begin
                    nxt_state = ST_ENTRY;
                end else begin
                    nxt_timer = timer + TMR_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    nxt_state = ST_ENTRY;
                    nxt_fail  = 4'd0;
                end else begin
                    nxt_timer = timer + TMR_W'(1);
                end
            end
`ifdef FSM_LOCK_PROG_EN
            ST_PROG: begin
                if (press && !multi) begin
                    nxt_prog[int'(dig_cnt)*IDX_W +: IDX_W] = press_idx;
                    if (dig_cnt == LAST_DIG) begin
                        // Whole new code lands in one edge; a partial code is never live.
                        nxt_code  = nxt_prog;
                        nxt_state = ST_ENTRY;
                        nxt_fail  = 4'd0;
                        nxt_cnt   = 4'd0;
                    end else begin
                        nxt_cnt = dig_cnt + 4'd1;
                    end
                end
            end
`endif
            default: nxt_state = ST_ENTRY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // Outputs are registered from the next-state values, giving no combinational path from btn_in.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state            <= ST_ENTRY;
            btn_q            <= '0;
            dig_cnt          <= 4'd0;
            mismatch         <= 1'b0;
            fail_cnt         <= 4'd0;
            timer            <= '0;
            bus.out          <= 1'b0;
            bus.lockout_out  <= 1'b0;
            bus.fail_cnt_out <= 4'd0;
            bus.hex_display  <= SEG_0;
        end else begin
            state            <= nxt_state;
            btn_q            <= bus.btn_in;
            dig_cnt          <= nxt_cnt;
            mismatch         <= nxt_mis;
            fail_cnt         <= nxt_fail;
            timer            <= nxt_timer;
            bus.out          <= (nxt_state == ST_OPEN);
            bus.lockout_out  <= (nxt_state == ST_LOCKOUT);
            bus.fail_cnt_out <= nxt_fail;
            bus.hex_display  <= seg_of(nxt_state, nxt_cnt);
        end
    end

`ifdef FSM_LOCK_PROG_EN
    // NOTE: the code register and entry buffer are reset, so reset always restores CODE and drops a partial entry.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            code_reg <= CODE;
            prog_buf <= '0;
        end else begin
            code_reg <= nxt_code;
            prog_buf <= nxt_prog;
        end
    end
`endif

endmodule
